pmp_check_seq: RTL and testbench
================================

PMP_CHECK_SEQ -- requirements
Module: pmp_check_seq

Interface
REQ-001 Parameter: NUM_ENTRIES, default 8, number of PMP entries; power of two, 2..16; IW = log2(NUM_ENTRIES).
REQ-002 clk  in  1  single clock for all sequential logic; rising edge.
REQ-003 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 req_valid  in  1; req_ready  out  1: access-check request handshake.
REQ-005 req_addr  in  34  physical byte address; req_size  in  2  access size code; req_type  in  2  00=read, 01=write, 10=exec, 11=illegal; req_mmode  in  1  requester is M-mode.
REQ-006 resp_valid  out  1; resp_ready  in  1: response handshake.
REQ-007 resp_allow  out  1  access permitted; resp_hit  out  1  an entry matched; resp_idx  out  IW  index of the matching entry.
REQ-008 cfg_we  in  1; cfg_ready  out  1; cfg_sel  in  1  0=cfg byte, 1=address; cfg_idx  in  IW; cfg_wdata  in  32: configuration write port.
REQ-009 Per-entry cfg byte: bit0 R, bit1 W, bit2 X, bits4:3 A (00 OFF, 01 TOR, 10 NA4, 11 NAPOT), bit7 L; bits6:5 read as 0. Address register is 32 bits in word units.

Function
REQ-010 FSM states: IDLE, SCAN, RESP; req_ready = (state==IDLE); cfg_ready = (state==IDLE).
REQ-011 IDLE->SCAN on req_valid&&req_ready; latch addr, size, type, mmode; scan index k=0.
REQ-012 SCAN evaluates exactly one entry per cycle through a single shared matcher, in ascending index order.
REQ-013 Match terms: w = req_addr[33:2]; e = w + 2^req_size - 1, 32-bit wrapping; prev = addr[k-1], or 0 when k=0.
REQ-014 OFF: no match. TOR: w>=prev && e<addr[k]. NA4: w>=addr[k] && e<addr[k]+4, 32-bit wrapping.
REQ-015 NAPOT: t = count of trailing ones in addr[k].
- t>=31: lb=0, ub=0xFFFFFFFF.
- otherwise: lb = addr[k] with bits t:0 cleared; ub = lb + 2^(t+1).
- match when w>=lb && e<ub.
REQ-016 First match at entry k: go to RESP next cycle with resp_hit=1, resp_idx=k. Later entries are not evaluated.
REQ-017 No match after entry NUM_ENTRIES-1: go to RESP with resp_hit=0, resp_idx=0.
REQ-018 Latency: a match at entry k gives resp_valid k+1 cycles after the accept edge; no match gives NUM_ENTRIES+1 cycles.
REQ-019 resp_allow on a hit:
- req_type=11: 0.
- req_mmode=1 and L=0: 1.
- otherwise: the R, W or X bit selected by req_type.
REQ-020 resp_allow on a miss = req_mmode.
REQ-021 RESP holds resp_valid and all response fields stable until resp_ready; RESP->IDLE on resp_valid&&resp_ready. No new request is accepted in that same cycle.
REQ-022 Config writes take effect only when cfg_we&&cfg_ready. cfg_sel=0 writes cfg_wdata[7:0] with bits6:5 forced to 0; cfg_sel=1 writes all 32 bits.
REQ-023 Lock rules:
- A write to a cfg byte with L=1 is ignored.
- A write to addr[i] is ignored when cfg[i].L=1.
- A write to addr[i] is also ignored when cfg[i+1].L=1 and cfg[i+1].A=TOR.
- L clears only on reset.
REQ-024 A config write and a request accept on the same edge: the write lands first, and the SCAN cycle for k=0 uses the updated values.
REQ-025 Outputs are registered or decoded from FSM state only; no combinational path from req_* to resp_*.

Reset
REQ-026 On rst_n low, immediately:
- state=IDLE.
- All cfg bytes and addresses = 0.
- resp_valid=0, resp_allow=0, resp_hit=0, resp_idx=0.
REQ-027 While and after reset, req_ready=1 and cfg_ready=1.
REQ-028 Reset during SCAN or RESP aborts the check; no response for that request is ever produced.

Verification
REQ-029 Miss: all entries OFF, request addr=0x1000, size=10, type=read, mmode=0 -> resp after 9 cycles (NUM_ENTRIES=8), hit=0, allow=0; repeat with mmode=1 -> allow=1.
REQ-030 TOR: addr[0]=0x400, cfg[0]=TOR|R; read at byte 0x0FF0 size=10 -> hit idx 0, allow=1, 1-cycle latency; write to the same address -> allow=0.
REQ-031 NAPOT plus priority:
- Setup: addr[2]=0x0000_01FF (lb=0, ub=0x400) with cfg[2]=NAPOT|RWX; entry 5 = NA4 with no perms at word 0x10.
- Read at 0x40 -> hit idx 2, allow=1, latency 3.
- Entry 2 set OFF -> hit idx 5, allow=0.
REQ-032 Lock:
- cfg[3]=L|TOR|R, then write cfg[3]=RWX|TOR -> read back unchanged.
- Write addr[2] -> ignored.
- M-mode write to the region -> allow=0.
REQ-033 Backpressure/reset: hold resp_ready=0 for 5 cycles -> response fields stable and req_ready=0; rst_n pulse low mid-SCAN -> resp_valid stays 0, all cfg read 0.

Source files
------------

// File: rtl/pmp_check_seq.sv
// pmp_check_seq: sequential PMP access checker, one entry per cycle through a shared matcher.
//   clk, rst_n                       : clock, async active-low reset
//   req_valid/req_ready, req_addr,
//   req_size, req_type, req_mmode    : access-check request
//   resp_valid/resp_ready, resp_allow,
//   resp_hit, resp_idx               : check result, held until accepted
//   cfg_we/cfg_ready, cfg_sel,
//   cfg_idx, cfg_wdata               : cfg byte (sel=0) or word-address (sel=1) write
module pmp_check_seq #(
  parameter int NUM_ENTRIES = 8,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [33:0]   req_addr,
  input  logic [1:0]    req_size,
  input  logic [1:0]    req_type,
  input  logic          req_mmode,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_allow,
  output logic          resp_hit,
  output logic [IW-1:0] resp_idx,
  input  logic          cfg_we,
  output logic          cfg_ready,
  input  logic          cfg_sel,
  input  logic [IW-1:0] cfg_idx,
  input  logic [31:0]   cfg_wdata
);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [IW:0] k;
  logic [7:0] cfg [NUM_ENTRIES];
  logic [31:0] addr [NUM_ENTRIES];
  logic [31:0] w, e, ka, prev, lb;
  logic [1:0] rtype;
  logic mmode;
  logic [NUM_ENTRIES-1:0] addr_lock;
  logic [IW-1:0] ki;
  logic [7:0] kc;
  logic [32:0] ub;
  logic [5:0] t;
  logic f, tor, na4, napot, match, allow;
  logic unused_ok;
  assign unused_ok = ^req_addr[1:0];
  assign req_ready = state == IDLE;
  assign cfg_ready = state == IDLE;
  assign resp_valid = state == RESP;
  // An address is also frozen when the next entry is a locked TOR using it as its base.
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_lock
    if (g < NUM_ENTRIES - 1) begin : g_tor
      assign addr_lock[g] = cfg[g][7] | (cfg[g+1][7] & (cfg[g+1][4:3] == 2'b01));
    end else begin : g_last
      assign addr_lock[g] = cfg[g][7];
    end
  end
  always_comb begin
    ki = k[IW-1:0];
    kc = cfg[ki];
    ka = addr[ki];
    prev = (ki == '0) ? '0 : addr[ki - IW'(1)];
    t = '0;
    f = 1'b1;
    for (int i = 0; i < 32; i++)
      if (f && ka[i]) t = t + 6'd1;
      else f = 1'b0;
    lb = (t >= 6'd31) ? '0 : ka & ~((32'd1 << (t + 6'd1)) - 32'd1);
    // ub can reach 2^32 for t=30, so it is kept one bit wider than the address.
    ub = (t >= 6'd31) ? 33'h0_FFFF_FFFF : {1'b0, lb} + (33'd1 << (t + 6'd1));
    tor = w >= prev && e < ka;
    na4 = w >= ka && e < ka + 32'd4;
    napot = w >= lb && {1'b0, e} < ub;
    // k[IW] marks the extra cycle after the last entry, where nothing may match.
    match = !k[IW] && (kc[4:3] == 2'b01 ? tor : kc[4:3] == 2'b10 ? na4 : kc[4:3] == 2'b11 ? napot : 1'b0);
    allow = (rtype == 2'b11) ? 1'b0 : (mmode && !kc[7]) ? 1'b1 : kc[rtype];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      w <= '0;
      e <= '0;
      rtype <= '0;
      mmode <= 1'b0;
      resp_allow <= 1'b0;
      resp_hit <= 1'b0;
      resp_idx <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cfg[i] <= '0;
        addr[i] <= '0;
      end
    end else begin
      if (cfg_we && cfg_ready) begin
        if (!cfg_sel && !cfg[cfg_idx][7]) cfg[cfg_idx] <= cfg_wdata[7:0] & 8'h9F;
        if (cfg_sel && !addr_lock[cfg_idx]) addr[cfg_idx] <= cfg_wdata;
      end
      if (state == IDLE && req_valid) begin
        state <= SCAN;
        k <= '0;
        w <= req_addr[33:2];
        e <= req_addr[33:2] + (32'd1 << req_size) - 32'd1;
        rtype <= req_type;
        mmode <= req_mmode;
      end else if (state == SCAN) begin
        if (match || k[IW]) begin
          state <= RESP;
          resp_hit <= match;
          resp_idx <= match ? ki : '0;
          resp_allow <= match ? allow : mmode;
        end else k <= k + (IW+1)'(1);
      end else if (state == RESP && resp_ready) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_pmp_check_seq.sv
// tb_pmp_check_seq: directed and randomized checks of pmp_check_seq against a behavioural model.
module tb_pmp_check_seq;
  logic clk = 0, rst_n = 1;
  logic req_valid = 0, req_ready, req_mmode = 0;
  logic [33:0] req_addr = '0;
  logic [1:0] req_size = '0, req_type = '0;
  logic resp_valid, resp_ready = 0, resp_allow, resp_hit;
  logic [2:0] resp_idx;
  logic cfg_we = 0, cfg_ready, cfg_sel = 0;
  logic [2:0] cfg_idx = '0;
  logic [31:0] cfg_wdata = '0;
  int tests = 0, fails = 0;
  logic [7:0] mcfg [8];
  logic [31:0] maddr [8];

  pmp_check_seq #(.NUM_ENTRIES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_type(req_type), .req_mmode(req_mmode),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_allow(resp_allow),
    .resp_hit(resp_hit), .resp_idx(resp_idx), .cfg_we(cfg_we), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mcfg[i] = '0;
      maddr[i] = '0;
    end
  endtask

  task automatic mwrite(input logic sel, input logic [2:0] idx, input logic [31:0] d);
    logic locked;
    if (!sel) begin
      if (!mcfg[idx][7]) mcfg[idx] = d[7:0] & 8'h9F;
    end else begin
      locked = mcfg[idx][7] || (idx < 7 && mcfg[idx+1][7] && mcfg[idx+1][4:3] == 2'b01);
      if (!locked) maddr[idx] = d;
    end
  endtask

  // Walks the table in priority order with plain unsigned arithmetic.
  task automatic model(input logic [33:0] a, input logic [1:0] sz, input logic [1:0] ty, input logic mm,
                       output logic hit, output logic [2:0] idx, output logic allow, output int lat);
    logic [63:0] w, e, lo, hi, blk;
    logic m;
    int t;
    w = {32'd0, a[33:2]};
    e = (w + (64'd1 << sz) - 64'd1) & 64'hFFFF_FFFF;
    hit = 0; idx = 0; allow = mm; lat = 9;
    for (int k = 0; k < 8; k++) begin
      if (!hit) begin
        m = 0;
        if (mcfg[k][4:3] == 2'b01) begin
          lo = (k == 0) ? 64'd0 : {32'd0, maddr[k-1]};
          m = w >= lo && e < {32'd0, maddr[k]};
        end else if (mcfg[k][4:3] == 2'b10) begin
          m = w >= {32'd0, maddr[k]} && e < ((64'd4 + maddr[k]) & 64'hFFFF_FFFF);
        end else if (mcfg[k][4:3] == 2'b11) begin
          t = 0;
          while (t < 32 && maddr[k][t]) t++;
          if (t >= 31) begin
            lo = 0; hi = 64'hFFFF_FFFF;
          end else begin
            blk = 64'd1 << (t + 1);
            lo = ({32'd0, maddr[k]} / blk) * blk;
            hi = lo + blk;
          end
          m = w >= lo && e < hi;
        end
        if (m) begin
          hit = 1; idx = 3'(k); lat = k + 1;
          allow = (ty == 2'b11) ? 1'b0 : (mm && !mcfg[k][7]) ? 1'b1 : mcfg[k][ty];
        end
      end
    end
  endtask

  task automatic cfgw(input logic sel, input logic [2:0] idx, input logic [31:0] d);
    cfg_we = 1; cfg_sel = sel; cfg_idx = idx; cfg_wdata = d;
    mwrite(sel, idx, d);
    @(posedge clk); #1;
    cfg_we = 0;
  endtask

  task automatic issue(input logic [33:0] a, input logic [1:0] sz, input logic [1:0] ty, input logic mm);
    req_valid = 1; req_addr = a; req_size = sz; req_type = ty; req_mmode = mm;
    @(posedge clk); #1;
    req_valid = 0; cfg_we = 0;
  endtask

  task automatic collect(input int hold, output int lat, output logic hit, output logic [2:0] idx, output logic allow);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    hit = resp_hit; idx = resp_idx; allow = resp_allow;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", resp_valid, 1);
      chk("hold_fields", {resp_hit, resp_idx, resp_allow}, {hit, idx, allow});
      chk("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    chk("back_to_idle", {req_ready, resp_valid}, 2'b10);
  endtask

  task automatic run_chk(input string tag, input logic [33:0] a, input logic [1:0] sz, input logic [1:0] ty,
                         input logic mm, input int hold);
    logic h, eh, al, eal;
    logic [2:0] ix, eix;
    int lat, elat;
    model(a, sz, ty, mm, eh, eix, eal, elat);
    issue(a, sz, ty, mm);
    collect(hold, lat, h, ix, al);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_hit"}, h, eh);
    chk({tag, "_idx"}, ix, eix);
    chk({tag, "_allow"}, al, eal);
  endtask

  initial begin
    logic seen;
    model_reset();
    #2 rst_n = 0;
    #3;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_resp", {resp_valid, resp_allow, resp_hit, resp_idx}, 6'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("post_rst_ready", {req_ready, cfg_ready, resp_valid}, 3'b110);

    run_chk("miss_u", 34'h1000, 2'b10, 2'b00, 0, 0);
    run_chk("miss_m", 34'h1000, 2'b10, 2'b00, 1, 0);

    cfgw(1, 0, 32'h400);
    cfgw(0, 0, 32'h09);
    run_chk("tor_read", 34'h0FF0, 2'b10, 2'b00, 0, 0);
    run_chk("tor_write", 34'h0FF0, 2'b10, 2'b01, 0, 0);
    run_chk("tor_edge", 34'h0FF4, 2'b10, 2'b00, 0, 0);

    cfgw(0, 0, 32'h00);
    cfgw(1, 2, 32'h1FF);
    cfgw(0, 2, 32'h1F);
    cfgw(1, 5, 32'h10);
    cfgw(0, 5, 32'h10);
    run_chk("napot_read", 34'h40, 2'b00, 2'b00, 0, 0);
    cfgw(0, 2, 32'h00);
    run_chk("na4_prio", 34'h40, 2'b00, 2'b00, 0, 0);

    cfgw(0, 5, 32'h00);
    cfgw(1, 3, 32'h800);
    cfgw(0, 3, 32'h89);
    cfgw(0, 3, 32'h0F);
    cfgw(1, 2, 32'h50);
    run_chk("lock_m_write", 34'h1000, 2'b00, 2'b01, 1, 0);
    run_chk("lock_m_read", 34'h1000, 2'b00, 2'b00, 1, 0);
    run_chk("lock_cfg_kept", 34'h1000, 2'b00, 2'b01, 0, 0);
    run_chk("lock_addr_kept", 34'h180, 2'b00, 2'b00, 0, 0);
    run_chk("illegal_type", 34'h1000, 2'b00, 2'b11, 1, 0);
    run_chk("backpressure", 34'h1000, 2'b01, 2'b00, 0, 5);

    issue(34'h4000, 2'b00, 2'b00, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_rst_state", {resp_valid, req_ready, cfg_ready}, 3'b011);
    @(posedge clk); #1 rst_n = 1;
    model_reset();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen |= resp_valid;
    end
    chk("abort_no_resp", seen, 0);
    run_chk("cfg_cleared", 34'h1000, 2'b00, 2'b00, 0, 0);

    cfgw(1, 0, 32'h100);
    cfg_we = 1; cfg_sel = 0; cfg_idx = 0; cfg_wdata = 32'h09;
    mwrite(0, 0, 32'h09);
    run_chk("same_edge_cfg", 34'h0, 2'b00, 2'b00, 0, 0);

    cfgw(0, 0, 32'h00);
    cfgw(1, 1, 32'hFFFF_FFFF);
    cfgw(0, 1, 32'h19);
    run_chk("napot_full_top", {32'hFFFF_FFFF, 2'b00}, 2'b00, 2'b00, 0, 0);
    run_chk("napot_full_in", {32'hFFFF_FFFE, 2'b00}, 2'b00, 2'b00, 0, 0);
    cfgw(0, 1, 32'h00);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1)
          cfgw(1, 3'($urandom), 32'($urandom_range(0, 'h300)));
        else
          cfgw(0, 3'($urandom), {24'd0, 8'($urandom) & 8'h7F | (($urandom_range(0, 9) == 0) ? 8'h80 : 8'h00)});
      end
      run_chk("rnd", {32'($urandom_range(0, 'h320)), 2'($urandom)}, 2'($urandom), 2'($urandom),
              1'($urandom), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
